// File: rtl/z80_io_decoder.sv
// Z80 I/O port decoder: synchronises the Z80 strobes, decodes the port address into one
// active-low chip select per channel, and stretches the cycle with WAIT# for a fixed count.
module z80_io_decoder #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter logic [NUM_CH*ADDR_W-1:0] BASES = {8'hDF, 8'hEF},
    parameter logic [NUM_CH*ADDR_W-1:0] MASKS = {8'hFF, 8'hFF},
    parameter int WAIT_CYCLES = 2,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iorq,
    input  logic              m1,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] A,
    output logic [NUM_CH-1:0] cs_n,
    output logic              ioge,
    output logic              wait_n,
    output logic [IDX_W-1:0]  ch_idx,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_IGNORE  = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] cs_n_q, cs_n_d;
    logic              ioge_q, ioge_d;
    logic              wait_n_q, wait_n_d;
    logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;

    // Strobes idle high, so the chains preset to 1 and never fake an access after reset.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic iorq_s, m1_s, rd_s, wr_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {iorq, m1, rd, wr}};
        end
    end

    assign {iorq_s, m1_s, rd_s, wr_s} = sync_q[SYNC_STAGES-1];

    logic access;
    logic intack;
    assign access = !iorq_s && m1_s && (!rd_s || !wr_s);
    assign intack = !iorq_s && !m1_s;

    // Walk from the top index down so the lowest matching channel wins.
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (((A ^ BASES[i*ADDR_W +: ADDR_W]) & MASKS[i*ADDR_W +: ADDR_W]) == '0) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_n_d   = cs_n_q;
        ioge_d   = ioge_q;
        wait_n_d = wait_n_q;
        ch_idx_d = ch_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (access && hit) begin
                    ch_idx_d = hit_idx;
                    cs_n_d   = ~(NUM_CH'(1) << hit_idx);
                    ioge_d   = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        wait_n_d = 1'b0;
                        cnt_d    = CNT_W'(WAIT_CYCLES - 1);
                        state_d  = ST_WAIT;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (access || intack) begin
                    state_d = ST_IGNORE;
                end
            end
            ST_WAIT: begin
                if (iorq_s) begin
                    cs_n_d   = '1;
                    ioge_d   = 1'b0;
                    wait_n_d = 1'b1;
                    state_d  = ST_RECOVER;
                end else if (cnt_q == '0) begin
                    wait_n_d = 1'b1;
                    state_d  = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (iorq_s) begin
                    cs_n_d  = '1;
                    ioge_d  = 1'b0;
                    state_d = ST_RECOVER;
                end
            end
            ST_IGNORE: begin
                if (iorq_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                cs_n_d   = '1;
                ioge_d   = 1'b0;
                wait_n_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cs_n_q   <= '1;
            ioge_q   <= 1'b0;
            wait_n_q <= 1'b1;
            ch_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_n_q   <= cs_n_d;
            ioge_q   <= ioge_d;
            wait_n_q <= wait_n_d;
            ch_idx_q <= ch_idx_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign ioge      = ioge_q;
    assign wait_n    = wait_n_q;
    assign ch_idx    = ch_idx_q;
    assign state_dbg = state_q;

endmodule
